// File: rtl/kbd_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard peripheral: bus constants,
// register selects, STATUS bit positions, receiver states and the frame check.
package kbd_ps2_pkg;

   // Bus slot shared with the other memory-mapped peripherals.
   localparam int   DATA_W   = 32;
   localparam logic MEM_READ = 1'b1;

   // Register selects (addr[1:0]).
   localparam logic [1:0] KBD_DATA = 2'd0;
   localparam logic [1:0] KBD_STAT = 2'd1;

   // STATUS register bit positions.
   localparam int ST_NONEMPTY = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_OVF      = 2;
   localparam int ST_ERR      = 3;
   localparam int ST_CNT_LO   = 8;

   // Receiver frame position: start, eight data bits, parity, stop.
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   // A frame is good when the stop bit is high and data plus parity has odd weight.
   function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                     input logic stop);
      return stop & (^{data, parity});
   endfunction

endpackage

// File: rtl/kbd_ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the raw pins, detects falling
// clock edges, shifts in an 11-bit frame LSB first and checks parity/stop.
// An idle gap of TIMEOUT cycles inside a frame aborts it as an error.
//
// Output handshake: byte_valid_o and frame_err_o are single-cycle pulses with
// no ready/back-pressure; byte_o is valid only while byte_valid_o is high, and
// the consumer must take or drop the byte in that same cycle.
module kbd_ps2_rx
   import kbd_ps2_pkg::*;
#(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o,
   output logic [1:0] state_o
);

   localparam int                TMO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT - 1);

   logic             clk_meta_q, clk_s_q, clk_prev_q;
   logic             data_meta_q, data_s_q;
   logic             fall;

   rx_state_e        state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   // Two-flop synchronisers plus one extra clock sample for edge detection;
   // idle-high reset values keep a reset release from looking like an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_meta_q  <= 1'b1;
         clk_s_q     <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_s_q    <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk_i;
         clk_s_q     <= clk_meta_q;
         clk_prev_q  <= clk_s_q;
         data_meta_q <= ps2_data_i;
         data_s_q    <= data_meta_q;
      end
   end

   assign fall = clk_prev_q & ~clk_s_q;

   // Receiver state, shift register and inactivity counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RX_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
      end
   end

   // Frame sequencing on each falling edge; timeout abort between edges.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;

      // The counter saturates so a long idle period never wraps into a false abort.
      if (fall)
         tmo_d = '0;
      else if (tmo_q == TMO_MAX)
         tmo_d = tmo_q;
      else
         tmo_d = tmo_q + TMO_W'(1);

      if (fall) begin
         unique case (state_q)
            RX_IDLE: begin
               if (!data_s_q) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = '0;
               end
            end
            RX_DATA: begin
               shift_d = {data_s_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7)
                  state_d = RX_PARITY;
               else
                  bit_cnt_d = bit_cnt_q + 3'd1;
            end
            RX_PARITY: begin
               par_d   = data_s_q;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               state_d = RX_IDLE;
               if (frame_ok(shift_q, par_q, data_s_q))
                  byte_valid_o = 1'b1;
               else
                  frame_err_o = 1'b1;
            end
            default: state_d = RX_IDLE;
         endcase
      end else if ((state_q != RX_IDLE) && (tmo_q == TMO_MAX)) begin
         state_d     = RX_IDLE;
         frame_err_o = 1'b1;
      end
   end

   assign byte_o  = shift_q;
   assign state_o = state_q;

endmodule

// File: rtl/kbd_ps2.sv
// Memory-mapped PS/2 keyboard port: queues received scancodes in a small FIFO
// and exposes DATA (pop on read) and STATUS (sticky ovf/err) registers.
module kbd_ps2
   import kbd_ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              rw,
   input  logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ps2_clk,
   input  logic              ps2_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             rx_valid, rx_err;
   logic [7:0]       rx_byte;
   logic [1:0]       rx_state;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, status;

   logic             rd_en, wr_en, empty, full, pop, push, ovf_set, stat_wr;
   logic [1:0]       sel;
   logic             unused_bits;

   kbd_ps2_rx #(
      .TIMEOUT (TIMEOUT)
   ) u_rx (
      .clk_i        (clk),
      .rst_ni       (rst),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_valid_o (rx_valid),
      .byte_o       (rx_byte),
      .frame_err_o  (rx_err),
      .state_o      (rx_state)
   );

   // Bus decode, FIFO bookkeeping, sticky flags and read data selection.
   always_comb begin
      sel     = addr[1:0];
      rd_en   = ena && (rw == MEM_READ);
      wr_en   = ena && (rw != MEM_READ);
      stat_wr = wr_en && (sel == KBD_STAT);
      empty   = (count_q == '0);
      full    = (count_q == CNT_W'(FIFO_DEPTH));
      pop     = rd_en && (sel == KBD_DATA) && !empty;
      // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
      push    = rx_valid && (!full || pop);
      ovf_set = rx_valid && full && !pop;

      wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Clear first so that a set event in the same cycle wins.
      ovf_d = ovf_q;
      if (stat_wr && wdata[ST_OVF]) ovf_d = 1'b0;
      if (ovf_set)                  ovf_d = 1'b1;
      err_d = err_q;
      if (stat_wr && wdata[ST_ERR]) err_d = 1'b0;
      if (rx_err)                   err_d = 1'b1;

      status                          = '0;
      status[ST_NONEMPTY]             = !empty;
      status[ST_FULL]                 = full;
      status[ST_OVF]                  = ovf_q;
      status[ST_ERR]                  = err_q;
      status[ST_CNT_LO +: CNT_W]      = count_q;

      rdata_d = rdata_q;
      if (rd_en) begin
         unique case (sel)
            KBD_DATA: rdata_d = empty ? '0 : {{(DATA_W-8){1'b0}}, mem_q[rptr_q]};
            KBD_STAT: rdata_d = status;
            default:  rdata_d = '0;
         endcase
      end
   end

   // Control state: pointers, occupancy, sticky flags and registered read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Scancode storage; contents are only observable through the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= rx_byte;
   end

   assign rdata = rdata_q;

   // Address and write-data bits outside the decoded fields, plus the receiver
   // state tap, are intentionally not used here.
   assign unused_bits = ^{addr[DATA_W-1:2], wdata[DATA_W-1:4], wdata[1:0], rx_state};

endmodule

// File: tb/tb_kbd_ps2.sv
// Directed bench for kbd_ps2: drives PS/2 frames bit by bit on the raw pins
// and checks DATA/STATUS reads against hand-computed values.
module tb_kbd_ps2;
  import kbd_ps2_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];

  kbd_ps2 #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .rw       (rw),
    .addr     (addr),
    .rdata    (rdata),
    .wdata    (wdata),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  // clock / reset
  always #10 clk = ~clk;

  // comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // PS/2 driver: 16 system clocks per bit, data set while ps2_clk is high
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    wait_neg(3);
    ps2_clk = 1'b0;
    wait_neg(8);
    ps2_clk = 1'b1;
    wait_neg(4);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    wait_neg(4);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(mk_frame(b, ~^b), 11);
  endtask

  // bus driver: rdata sampled on the negedge after the access edge
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    ena = 1'b1; rw = MEM_READ; addr = {30'b0, a};
    @(negedge clk);
    ena = 1'b0; rw = 1'b0; addr = '0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ena = 1'b1; rw = ~MEM_READ; addr = {30'b0, a}; wdata = d;
    @(negedge clk);
    ena = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
  endtask

  // scoreboard-backed DATA read
  task automatic read_expect(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(KBD_DATA, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check(tag, d, {24'b0, e});
  endtask

  initial begin
    logic [31:0] d;
    logic [10:0] f;

    // reset state
    wait_neg(3);
    check("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    wait_neg(2);
    bus_read(KBD_STAT, d);
    check("reset_status", d, 32'h000);
    bus_read(KBD_DATA, d);
    check("empty_data_read", d, 32'h0);

    // single good frame 0x1C, parity 0
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    exp_q.push_back(8'h1C);
    bus_read(KBD_STAT, d);
    check("status_one_byte", d, 32'h101);
    read_expect("data_1c");
    bus_read(KBD_STAT, d);
    check("status_after_pop", d, 32'h000);

    // bad parity: nothing queued, err set, cleared by write
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    bus_read(KBD_STAT, d);
    check("status_parity_err", d, 32'h008);
    bus_write(KBD_STAT, 32'h8);
    bus_read(KBD_STAT, d);
    check("status_err_cleared", d, 32'h000);

    // overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    bus_read(KBD_STAT, d);
    check("status_full_ovf", d, 32'h807);
    write_rdata_hold_check();
    for (int i = 1; i <= 8; i++) read_expect($sformatf("drain_%0d", i));
    bus_read(KBD_DATA, d);
    check("ninth_read_empty", d, 32'h0);
    bus_read(KBD_STAT, d);
    check("status_ovf_sticky", d, 32'h004);
    bus_write(KBD_STAT, 32'h4);
    bus_read(KBD_STAT, d);
    check("status_ovf_cleared", d, 32'h000);

    // partial frame aborted by timeout, then a clean 0xF0
    send_bits(mk_frame(8'h55, 1'b1), 4);
    wait_neg(220);
    send_good(8'hF0);
    exp_q.push_back(8'hF0);
    bus_read(KBD_STAT, d);
    check("status_timeout", d, 32'h109);
    read_expect("data_f0");
    bus_write(KBD_STAT, 32'h8);
    bus_read(KBD_STAT, d);
    check("status_clean", d, 32'h000);

    // pop coinciding with the push of the next byte
    send_good(8'h12);
    exp_q.push_back(8'h12);
    f = mk_frame(8'h34, ~^8'h34);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_neg(3);
    ps2_clk = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h34);
    read_expect("data_12_at_push");
    wait_neg(5);
    ps2_clk = 1'b1;
    wait_neg(8);
    bus_read(KBD_STAT, d);
    check("status_count_kept", d, 32'h101);
    read_expect("data_34");

    // reset in the middle of a frame
    f = mk_frame(8'h77, ~^8'h77);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    @(negedge clk);
    ps2_data = f[5];
    wait_neg(3);
    ps2_clk = 1'b0;
    wait_neg(4);
    rst = 1'b0;
    #1;
    check("midframe_reset_rdata", rdata, 32'h0);
    wait_neg(2);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_neg(2);
    rst = 1'b1;
    wait_neg(2);
    bus_read(KBD_STAT, d);
    check("midframe_reset_status", d, 32'h000);
    send_good(8'h5A);
    exp_q.push_back(8'h5A);
    bus_read(KBD_STAT, d);
    check("status_after_reset_frame", d, 32'h101);
    read_expect("data_5a");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // a write must leave rdata holding the previous read value (STATUS 0x807 here)
  task automatic write_rdata_hold_check();
    bus_write(2'd0, 32'hFFFF_FFFF);
    check("rdata_hold_on_write", rdata, 32'h807);
  endtask

endmodule
